dff_pipe: RTL and testbench
===========================

DFF_PIPE -- requirements
Module: dff_pipe

Interface
REQ-001: Parameter WIDTH, default 1, bit width of the data path; legal range 1 and above.
REQ-002: Parameter DEPTH, default 1, number of register stages (the latency); legal range 1 and above.
REQ-003: Parameter RST_VAL, default 0, WIDTH-bit value loaded into every data stage on reset or flush.
REQ-004: Parameter MASK_INVALID, default 0; when 1, a stage captures RST_VAL instead of the data whenever its incoming valid is 0.
REQ-005: Port clk, input, 1 bit, the only clock; all state changes on its rising edge.
REQ-006: Port rst, input, 1 bit, synchronous active-high reset.
REQ-007: Port en, input, 1 bit, advance enable; 0 stalls the whole pipe.
REQ-008: Port flush, input, 1 bit, synchronous clear of all stage contents and valids.
REQ-009: Port in, input, WIDTH bits, data into stage 0.
REQ-010: Port in_valid, input, 1 bit, qualifies in.
REQ-011: Port out, output, WIDTH bits, content of the last stage (registered, no combinational path from any input).
REQ-012: Port out_valid, output, 1 bit, valid bit of the last stage.
REQ-013: Port count, output, CW = clog2(DEPTH+1) bits, number of stages currently holding valid data.

Function
REQ-014: Priority per edge SHALL be rst > flush > en > hold.
REQ-015: With en=1 (no rst/flush), stage 0 SHALL capture {in, in_valid} and stage k SHALL capture stage k-1, for k = 1..DEPTH-1.
REQ-016: With en=0 (no rst/flush), every stage, out, out_valid and count SHALL hold their values.
REQ-017: Latency SHALL be exactly DEPTH enabled edges from the in/in_valid sample to its appearance on out/out_valid; stalled cycles add one cycle each.
REQ-018: With MASK_INVALID=0, data SHALL shift regardless of valid; with MASK_INVALID=1, an invalid slot SHALL carry RST_VAL, so out equals RST_VAL whenever out_valid=0.
REQ-019: On an enabled edge, count SHALL become count + in_valid - out_valid (pre-edge values); a simultaneous entry and exit SHALL leave count unchanged.
REQ-020: count SHALL never exceed DEPTH nor underflow; it SHALL always equal the population of the valid bits.
REQ-021: flush SHALL set all data stages to RST_VAL, all valids to 0 and count to 0 on the next edge, ignoring en, in and in_valid in that cycle.
REQ-022: With DEPTH=1, WIDTH=1 and en tied high, the block SHALL behave as a single D flip-flop: out follows in one edge later.

Reset
REQ-023: While rst=1 at an edge, every data stage and out SHALL become RST_VAL, every valid and out_valid SHALL become 0, and count SHALL become 0.
REQ-024: rst asserted mid-stream SHALL discard all in-flight data with no partial shift; the first enabled edge after rst deasserts SHALL load stage 0 normally.
REQ-025: No output SHALL be X after the first edge with rst=1.

Structure
REQ-026: Package dff_pkg SHALL hold the parameter defaults (WIDTH, DEPTH, RST_VAL, MASK_INVALID) and the CW width function.
REQ-027: The pipe SHALL be built from DEPTH instances of a sub-module dff_stage: one WIDTH+1-bit register with sync rst, clear (flush) and enable, reset to {RST_VAL, 0}.
REQ-028: count SHALL be a separate registered counter, not derived combinationally from the valid bits.

Verification (WIDTH=8, DEPTH=3, RST_VAL=0, unless noted)
REQ-029: Hold rst for 2 edges with in=0xFF and in_valid=1 -> out=0x00, out_valid=0, count=0 throughout reset.
REQ-030: With en=1, drive 0xA5 valid for 1 cycle, then invalid -> out=0xA5 with out_valid=1 for exactly one cycle, starting at the 3rd edge; count goes 1,1,1,0.
REQ-031: Drive 0x11 then 0x22 valid, then en=0 for 2 cycles -> all outputs frozen with count=2; after en=1 resumes, 0x11 then 0x22 appear on consecutive cycles.
REQ-032: Stream 0x01..0x05 valid back-to-back -> count saturates at 3; out shows 0x01..0x05 from the 3rd edge onward with no gaps.
REQ-033: Assert flush together with en=1, in_valid=1 and in=0x77 while the pipe is full -> next cycle count=0, out_valid=0, out=0x00, and 0x77 never emerges.
REQ-034: Set MASK_INVALID=1 and send an invalid slot carrying in=0x5A -> out=0x00 while out_valid=0. Set DEPTH=1, WIDTH=1 and toggle in -> out follows in one edge later.

Source files
------------

// File: rtl/dff_pkg.sv
// Shared defaults and helpers for the dff_pipe register pipeline.
// Imported by dff_stage and dff_pipe so parameter defaults live in one place.
package dff_pkg;

  localparam int unsigned DefaultWidth       = 1;
  localparam int unsigned DefaultDepth       = 1;
  localparam int unsigned DefaultRstVal      = 0;
  localparam bit          DefaultMaskInvalid = 1'b0;

  // Bits needed to hold an occupancy value in 0..depth inclusive.
  function automatic int unsigned cnt_width(int unsigned depth);
    return unsigned'($clog2(depth + 1));
  endfunction

endpackage

// File: rtl/dff_stage.sv
// One pipeline slot: a WIDTH-bit data register plus its valid bit.
// Sync reset and clear both load {RST_VAL, 0}; reset wins over clear, clear over enable.
module dff_stage
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH        = DefaultWidth,
  parameter logic [WIDTH-1:0] RST_VAL      = WIDTH'(DefaultRstVal),
  parameter bit               MASK_INVALID = DefaultMaskInvalid
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  logic [WIDTH:0]   state_q, state_d;
  logic [WIDTH-1:0] d_masked;

  // An empty slot carries RST_VAL so downstream never sees stale payload.
  assign d_masked = (MASK_INVALID && !d_valid) ? RST_VAL : d;

  always_comb begin
    state_d = state_q;
    if (clr) begin
      state_d = {RST_VAL, 1'b0};
    end else if (en) begin
      state_d = {d_masked, d_valid};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= {RST_VAL, 1'b0};
    end else begin
      state_q <= state_d;
    end
  end

  assign q       = state_q[WIDTH:1];
  assign q_valid = state_q[0];

endmodule

// File: rtl/dff_pipe.sv
// DEPTH-stage register pipeline with valid tracking, stall, flush and an occupancy counter.
// Outputs come straight from flops; nothing combinational reaches out/out_valid/count.
module dff_pipe
  import dff_pkg::*;
#(
  parameter int unsigned      WIDTH        = DefaultWidth,
  parameter int unsigned      DEPTH        = DefaultDepth,
  parameter logic [WIDTH-1:0] RST_VAL      = WIDTH'(DefaultRstVal),
  parameter bit               MASK_INVALID = DefaultMaskInvalid
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          flush,
  input  logic [WIDTH-1:0]              in,
  input  logic                          in_valid,
  output logic [WIDTH-1:0]              out,
  output logic                          out_valid,
  output logic [cnt_width(DEPTH)-1:0]   count
);

  localparam int unsigned CW = cnt_width(DEPTH);

  // Index 0 is the pipe input; index k is the output of stage k-1.
  logic [WIDTH-1:0] stage_data [DEPTH+1];
  logic [DEPTH:0]   stage_valid;

  assign stage_data[0]  = in;
  assign stage_valid[0] = in_valid;

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    dff_stage #(
      .WIDTH        (WIDTH),
      .RST_VAL      (RST_VAL),
      .MASK_INVALID (MASK_INVALID)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (flush),
      .en      (en),
      .d       (stage_data[k]),
      .d_valid (stage_valid[k]),
      .q       (stage_data[k+1]),
      .q_valid (stage_valid[k+1])
    );
  end

  assign out       = stage_data[DEPTH];
  assign out_valid = stage_valid[DEPTH];

  logic [CW-1:0] count_q, count_d;

  // Modular add-then-subtract is exact: the result always lands in 0..DEPTH.
  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CW'(in_valid) - CW'(out_valid);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Scoreboard bench for dff_pipe: a history-of-accepted-slots model predicts every output,
// the driver queues the expectation per edge and a separate monitor compares after the edge.
module tb_dff_pipe;

  logic       clk = 1'b0;
  logic       rst, en, flush, din_valid;
  logic [7:0] din;
  logic       d1_in;

  logic [7:0] a_out, b_out, c_out;
  logic       a_v, b_v, c_v, d_out, d_v;
  logic [1:0] a_cnt, b_cnt;
  logic [2:0] c_cnt;
  logic       d_cnt;

  always #5 clk = ~clk;

  // A: WIDTH 8, DEPTH 3, RST_VAL 0, no masking.
  dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .MASK_INVALID(1'b0)) u_a (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in(din), .in_valid(din_valid),
    .out(a_out), .out_valid(a_v), .count(a_cnt));

  // B: same shape with masking of invalid slots.
  dff_pipe #(.WIDTH(8), .DEPTH(3), .RST_VAL(8'h00), .MASK_INVALID(1'b1)) u_b (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in(din), .in_valid(din_valid),
    .out(b_out), .out_valid(b_v), .count(b_cnt));

  // C: deeper pipe with a non-zero reset value.
  dff_pipe #(.WIDTH(8), .DEPTH(4), .RST_VAL(8'hC3), .MASK_INVALID(1'b0)) u_c (
    .clk(clk), .rst(rst), .en(en), .flush(flush), .in(din), .in_valid(din_valid),
    .out(c_out), .out_valid(c_v), .count(c_cnt));

  // D: plain single D flip-flop.
  dff_pipe u_d (
    .clk(clk), .rst(rst), .en(1'b1), .flush(1'b0), .in(d1_in), .in_valid(1'b1),
    .out(d_out), .out_valid(d_v), .count(d_cnt));

  typedef struct packed {logic [7:0] d; logic v;} slot_t;
  typedef struct {
    logic [7:0] ao; logic av; int ac;
    logic [7:0] bo; logic bv; int bc;
    logic [7:0] co; logic cv; int cc;
    logic       dout; logic dv; int dc;
  } exp_t;

  slot_t hist[$];     // slots accepted on enabled edges since the last clear, oldest first
  exp_t  exp_q[$];
  int    checks = 0;
  int    passes = 0;
  bit    drv_done = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act === want) passes++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
  endtask

  // A pipe of depth n shows the slot accepted n enabled edges ago, or its reset slot.
  function automatic void predict(input int n, input logic [7:0] rv, input bit mask,
                                  output logic [7:0] o, output logic v, output int cnt);
    int sz = hist.size();
    if (sz >= n) begin
      o = hist[sz-n].d;
      v = hist[sz-n].v;
    end else begin
      o = rv;
      v = 1'b0;
    end
    if (mask && !v) o = rv;
    cnt = 0;
    for (int i = (sz > n ? sz - n : 0); i < sz; i++) cnt += int'(hist[i].v);
  endfunction

  task automatic cyc(input bit r, input bit e, input bit f, input logic [7:0] d, input bit v);
    exp_t x;
    logic b1;
    rst = r; en = e; flush = f; din = d; din_valid = v;
    b1 = 1'($urandom_range(0, 1));
    d1_in = b1;
    @(posedge clk);
    if (r || f) hist.delete();
    else if (e) hist.push_back('{d: d, v: v});
    while (hist.size() > 8) void'(hist.pop_front());
    predict(3, 8'h00, 1'b0, x.ao, x.av, x.ac);
    predict(3, 8'h00, 1'b1, x.bo, x.bv, x.bc);
    predict(4, 8'hC3, 1'b0, x.co, x.cv, x.cc);
    x.dout = r ? 1'b0 : b1;
    x.dv   = !r;
    x.dc   = r ? 0 : 1;
    exp_q.push_back(x);
    @(negedge clk);
  endtask

  // Monitor: one expectation per edge, compared 1 ns after the edge.
  initial begin : monitor
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (drv_done && exp_q.size() == 0) break;
      if (exp_q.size() == 0) begin
        chk("scoreboard_empty", 32'd1, 32'd0);
        continue;
      end
      x = exp_q.pop_front();
      chk("a_out_valid", 32'(a_v), 32'(x.av));
      chk("a_count", 32'(a_cnt), 32'(x.ac));
      chk("a_out", 32'(a_out), 32'(x.ao));
      chk("b_out_valid", 32'(b_v), 32'(x.bv));
      chk("b_count", 32'(b_cnt), 32'(x.bc));
      chk("b_out", 32'(b_out), 32'(x.bo));
      chk("c_out_valid", 32'(c_v), 32'(x.cv));
      chk("c_count", 32'(c_cnt), 32'(x.cc));
      chk("c_out", 32'(c_out), 32'(x.co));
      chk("d_out", 32'(d_out), 32'(x.dout));
      chk("d_out_valid", 32'(d_v), 32'(x.dv));
      chk("d_count", 32'(d_cnt), 32'(x.dc));
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL timeout: got no finish, expected finish before 500000");
    $fatal(1, "timeout");
  end

  initial begin : driver
    // Reset with full-scale valid input present.
    repeat (2) cyc(1, 1, 0, 8'hFF, 1);
    // Single valid token followed by bubbles.
    cyc(0, 1, 0, 8'hA5, 1);
    repeat (4) cyc(0, 1, 0, 8'h00, 0);
    // Two tokens, a two-cycle stall, then drain.
    cyc(0, 1, 0, 8'h11, 1);
    cyc(0, 1, 0, 8'h22, 1);
    repeat (2) cyc(0, 0, 0, 8'h99, 1);
    repeat (4) cyc(0, 1, 0, 8'h00, 0);
    // Back-to-back stream.
    for (int i = 1; i <= 5; i++) cyc(0, 1, 0, 8'(i), 1);
    repeat (4) cyc(0, 1, 0, 8'h00, 0);
    // Flush a full pipe while a valid token is offered.
    for (int i = 0; i < 4; i++) cyc(0, 1, 0, 8'(8'h30 + i), 1);
    cyc(0, 1, 1, 8'h77, 1);
    repeat (5) cyc(0, 1, 0, 8'h00, 0);
    // Invalid slots carrying payload.
    repeat (4) cyc(0, 1, 0, 8'h5A, 0);
    // Reset mid-stream, then resume.
    cyc(0, 1, 0, 8'hE1, 1);
    cyc(0, 1, 0, 8'hE2, 1);
    cyc(1, 1, 0, 8'hE3, 1);
    cyc(0, 1, 0, 8'hE4, 1);
    repeat (4) cyc(0, 1, 0, 8'h00, 0);
    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 19) == 0), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    drv_done = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
